multicycle_control: RTL and testbench

Multi-cycle control FSM for the RV32I datapath: sequences fetch, decode, execute, memory and writeback, and drives the 3-bit `alu_op` code consumed by the ALU. It also produces the datapath mux selects, register/PC/IR write enables, and the request side of a single-port instruction/data memory handshake. It sits between the instruction register and the datapath.

---
 rtl/multicycle_control.sv | 247 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control
// ------------------
// Multi-cycle control FSM for an RV32I datapath. Sequences fetch, decode,
// execute, memory and writeback, drives the 3-bit ALU operation code, the
// datapath mux selects, the IR/PC/register write enables and the request side
// of a single-port instruction/data memory handshake.
//
// Optional feature macro: MC_CTRL_BRANCH_EN
//   defined     - BRANCH (BEQ/BNE) and JAL states and their decode are built.
//   not defined - branch and JAL opcodes decode to ILLEGAL, DECODE imm_src is I.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   instr      in   instruction register contents (valid from DECODE onward)
//   alu_zero   in   ALU result is zero
//   mem_ready  in   memory completes the current request this cycle
//   mem_req    out  memory access request
//   mem_we     out  memory write strobe (qualified by mem_req)
//   adr_src    out  memory address select: 0 = PC, 1 = ALUOut
//   ir_write   out  load IR and OldPC
//   pc_write   out  load PC from the result mux
//   reg_write  out  register-file write to rd
//   alu_src_a  out  00 = PC, 01 = OldPC, 10 = register A
//   alu_src_b  out  00 = register B, 01 = immediate, 10 = constant 4
//   imm_src    out  00 = I, 01 = S, 10 = B, 11 = J
//   result_src out  00 = ALUOut, 01 = memory data register, 10 = live ALU result
//   alu_op     out  ALU operation code
//   illegal    out  sticky unsupported-instruction flag
//   state      out  current FSM state (debug), FETCH = 0
//
// The control outputs are decoded combinationally from the state register so
// that rst forces every output low in the same cycle it is asserted (this is
// what aborts an in-flight memory request) and so that the FETCH write enables
// and the branch decision can follow mem_ready / alu_zero within the cycle.

module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_op,
  output logic        illegal,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_EXEC_R    = 4'd2,
    ST_EXEC_I    = 4'd3,
    ST_ALU_WB    = 4'd4,
    ST_MEM_ADDR  = 4'd5,
    ST_MEM_READ  = 4'd6,
    ST_MEM_WB    = 4'd7,
    ST_MEM_WRITE = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JAL       = 4'd10,
    ST_ILLEGAL   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
`ifdef MC_CTRL_BRANCH_EN
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [1:0] IMM_B    = 2'b10;
  localparam logic [1:0] IMM_J    = 2'b11;
`endif
  localparam logic [1:0] IMM_I    = 2'b00;
  localparam logic [1:0] IMM_S    = 2'b01;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  state_t     state_r;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       f3_bad_s;
  logic       unused_s;

  // funct3 -> ALU op; instr[30] selects SUB only for R-type, SRA for both
  function automatic logic [2:0] alu_dec(input logic [2:0] f3,
                                         input logic       b30,
                                         input logic       is_r);
    logic [2:0] op;
    case (f3)
      3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b100:  op = ALU_XOR;
      3'b101:  op = b30 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  assign opcode_s = instr[6:0];
  assign funct3_s = instr[14:12];
  // funct3 01x (SLT / SLTU) is an unsupported encoding
  assign f3_bad_s = (funct3_s[2:1] == 2'b01);
  assign unused_s = ^{instr[31], instr[29:15], instr[11:7], alu_zero};

  // State register and next-state sequencing
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FETCH;
    end else begin
      case (state_r)
        ST_FETCH:     if (mem_ready) state_r <= ST_DECODE;
        ST_DECODE: begin
          case (opcode_s)
            OP_R:              state_r <= ST_EXEC_R;
            OP_I:              state_r <= ST_EXEC_I;
            OP_LOAD, OP_STORE: state_r <= ST_MEM_ADDR;
`ifdef MC_CTRL_BRANCH_EN
            OP_BR:             state_r <= ST_BRANCH;
            OP_JAL:            state_r <= ST_JAL;
`endif
            default:           state_r <= ST_ILLEGAL;
          endcase
        end
        ST_EXEC_R,
        ST_EXEC_I:    state_r <= f3_bad_s ? ST_ILLEGAL : ST_ALU_WB;
        ST_ALU_WB:    state_r <= ST_FETCH;
        ST_MEM_ADDR: begin
          if (funct3_s != 3'b010)      state_r <= ST_ILLEGAL;
          else if (opcode_s == OP_LOAD) state_r <= ST_MEM_READ;
          else                          state_r <= ST_MEM_WRITE;
        end
        ST_MEM_READ:  if (mem_ready) state_r <= ST_MEM_WB;
        ST_MEM_WB:    state_r <= ST_FETCH;
        ST_MEM_WRITE: if (mem_ready) state_r <= ST_FETCH;
`ifdef MC_CTRL_BRANCH_EN
        ST_BRANCH:    state_r <= (instr[14:13] != 2'b00) ? ST_ILLEGAL : ST_FETCH;
        ST_JAL:       state_r <= ST_ALU_WB;
`endif
        ST_ILLEGAL:   state_r <= ST_ILLEGAL;
        default:      state_r <= ST_FETCH;
      endcase
    end
  end

  // Control output decode; everything low while rst is asserted
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = IMM_I;
    result_src = 2'b00;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    state      = 4'd0;
    if (rst) begin
      state = 4'd0;
    end else begin
      state = state_r;
      case (state_r)
        ST_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
`ifdef MC_CTRL_BRANCH_EN
          if (opcode_s == OP_BR)       imm_src = IMM_B;
          else if (opcode_s == OP_JAL) imm_src = IMM_J;
          else                         imm_src = IMM_I;
`endif
        end
        ST_EXEC_R: begin
          alu_src_a = 2'b10;
          alu_op    = alu_dec(funct3_s, instr[30], 1'b1);
        end
        ST_EXEC_I: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = alu_dec(funct3_s, instr[30], 1'b0);
        end
        ST_ALU_WB:    reg_write = 1'b1;
        ST_MEM_ADDR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = (opcode_s == OP_STORE) ? IMM_S : IMM_I;
        end
        ST_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        ST_MEM_WB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        ST_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
`ifdef MC_CTRL_BRANCH_EN
        ST_BRANCH: begin
          alu_src_a = 2'b10;
          alu_op    = ALU_SUB;
          // instr[12] distinguishes BNE from BEQ; unsupported branches never write PC
          pc_write  = (instr[14:13] == 2'b00) ? (alu_zero ^ instr[12]) : 1'b0;
        end
        ST_JAL: begin
          pc_write  = 1'b1;
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
`endif
        ST_ILLEGAL:   illegal = 1'b1;
        default:      illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, a reset
// abort of a stalled store, and randomized instructions checked cycle by cycle
// against an instruction-level plan of control steps.

module tb_multicycle_control;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, alu_zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_op;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;

`ifdef MC_CTRL_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .alu_op(alu_op), .illegal(illegal), .state(state)
  );

  typedef enum int {K_FETCH, K_DEC, K_EXR, K_EXI, K_AWB, K_MADR, K_MRD, K_MWB,
                    K_MWR, K_BR, K_JAL, K_ILL} kind_t;

  typedef struct packed {
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, imm, res;
    logic [2:0] op;
    logic       ill;
  } ctl_t;

  typedef struct {
    string       name;
    logic [31:0] i;
    logic        z;
    int          waits;
    int          cyc;
    logic        ill;
    logic        chk_op;
    logic [2:0]  op;
  } vec_t;

  kind_t plan[$];
  vec_t  tbl[$];

  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic b30, input logic is_r);
    case (f3)
      3'd0:    return (is_r && b30) ? 3'b001 : 3'b000;
      3'd1:    return 3'b101;
      3'd4:    return 3'b100;
      3'd5:    return b30 ? 3'b111 : 3'b110;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Sequence of control steps an instruction goes through (from FETCH onward)
  task automatic make_plan(input logic [31:0] i);
    logic [2:0] f3;
    f3 = i[14:12];
    plan.delete();
    plan.push_back(K_FETCH);
    plan.push_back(K_DEC);
    case (i[6:0])
      7'b0110011: begin plan.push_back(K_EXR); plan.push_back((f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_AWB); end
      7'b0010011: begin plan.push_back(K_EXI); plan.push_back((f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_AWB); end
      7'b0000011: begin
        plan.push_back(K_MADR);
        if (f3 == 3'd2) begin plan.push_back(K_MRD); plan.push_back(K_MWB); end
        else plan.push_back(K_ILL);
      end
      7'b0100011: begin plan.push_back(K_MADR); plan.push_back((f3 == 3'd2) ? K_MWR : K_ILL); end
      7'b1100011: begin
        if (BR_EN) begin
          plan.push_back(K_BR);
          if (i[14:13] != 2'b00) plan.push_back(K_ILL);
        end else plan.push_back(K_ILL);
      end
      7'b1101111: begin
        if (BR_EN) begin plan.push_back(K_JAL); plan.push_back(K_AWB); end
        else plan.push_back(K_ILL);
      end
      default: plan.push_back(K_ILL);
    endcase
  endtask

  function automatic ctl_t exp_ctl(input kind_t k, input logic [31:0] i, input logic rdy, input logic z);
    ctl_t c;
    c = '0;
    case (k)
      K_FETCH: begin c.mem_req = 1'b1; c.b = 2'd2; c.res = 2'd2; c.ir_write = rdy; c.pc_write = rdy; end
      K_DEC: begin
        c.a = 2'd1; c.b = 2'd1;
        if (BR_EN && i[6:0] == 7'b1100011) c.imm = 2'd2;
        if (BR_EN && i[6:0] == 7'b1101111) c.imm = 2'd3;
      end
      K_EXR:  begin c.a = 2'd2; c.op = ref_alu(i[14:12], i[30], 1'b1); end
      K_EXI:  begin c.a = 2'd2; c.b = 2'd1; c.op = ref_alu(i[14:12], i[30], 1'b0); end
      K_AWB:  c.reg_write = 1'b1;
      K_MADR: begin c.a = 2'd2; c.b = 2'd1; c.imm = (i[6:0] == 7'b0100011) ? 2'd1 : 2'd0; end
      K_MRD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      K_MWB:  begin c.reg_write = 1'b1; c.res = 2'd1; end
      K_MWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.adr_src = 1'b1; end
      K_BR:   begin c.a = 2'd2; c.op = 3'b001; c.pc_write = (i[14:13] == 2'b00) ? (z ^ i[12]) : 1'b0; end
      K_JAL:  begin c.pc_write = 1'b1; c.a = 2'd1; c.b = 2'd2; end
      K_ILL:  c.ill = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle: drive inputs, compare at the falling edge, advance
  task automatic step(input kind_t k, input logic rdy, input logic z, input string name,
                      output logic [2:0] op_seen);
    ctl_t e, a;
    mem_ready = rdy;
    alu_zero  = z;
    @(negedge clk);
    e = exp_ctl(k, instr, rdy, z);
    a = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
         alu_src_a, alu_src_b, imm_src, result_src, alu_op, illegal};
    op_seen = alu_op;
    // ALU code for unsupported funct3 is unspecified
    if ((k == K_EXR || k == K_EXI) && instr[14:13] == 2'b01) a.op = e.op;
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s ctl step=%0d instr=%h got=%b exp=%b", name, k, instr, a, e);
    end
    checks++;
    if ((k == K_FETCH) != (state === 4'd0)) begin
      failures++;
      $display("FAIL %s state step=%0d got=%0d required FETCH=%0d", name, k, state, (k == K_FETCH));
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    ctl_t a;
    rst = 1'b1; mem_ready = 1'b1; alu_zero = 1'b1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      a = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_op, illegal};
      checks++;
      if (a !== '0 || state !== 4'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%b state=%0d required all zero", a, state);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // Run one instruction from FETCH; random mode randomizes ready/zero per cycle
  task automatic run_instr(input string name, input logic [31:0] i, input logic rnd, input logic z,
                           input int waits, output int cyc, output logic hit_ill, output logic [2:0] op2);
    kind_t      k;
    int         w, tot;
    logic       rdy, zz, is_mem;
    logic [2:0] op_seen;
    instr = i; make_plan(i);
    cyc = 0; tot = 0; hit_ill = 1'b0; op2 = 3'd0;
    for (int p = 0; p < plan.size(); p++) begin
      k = plan[p];
      if (k == K_ILL) begin
        hit_ill = 1'b1;
        for (int n = 0; n < 3; n++) begin
          step(K_ILL, 1'($urandom), 1'($urandom), name, op_seen);
          if (tot == 2) op2 = op_seen;
          tot++;
        end
      end else begin
        is_mem = (k == K_FETCH || k == K_MRD || k == K_MWR);
        w = 0;
        do begin
          if (!is_mem)            rdy = 1'($urandom);
          else if (rnd)           rdy = (w >= 6) || ($urandom_range(0, 2) != 0);
          else if (k == K_FETCH)  rdy = 1'b1;
          else                    rdy = (w >= waits);
          zz = rnd ? 1'($urandom) : z;
          step(k, rdy, zz, name, op_seen);
          if (tot == 2) op2 = op_seen;
          tot++; cyc++; w++;
        end while (is_mem && !rdy);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        ill;
    logic [2:0]  op2, dummy;
    logic [31:0] r;
    logic [6:0]  opc;

    rst = 1'b1; instr = 32'd0; mem_ready = 1'b0; alu_zero = 1'b0;
    @(posedge clk); #1;
    do_reset(2);

    tbl.push_back('{"add",   32'h002081B3, 1'b0, 0, 4, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"sub",   32'h402081B3, 1'b0, 0, 4, 1'b0, 1'b1, 3'b001});
    tbl.push_back('{"srai",  32'h40335293, 1'b0, 0, 4, 1'b0, 1'b1, 3'b111});
    tbl.push_back('{"xori",  32'h0040C293, 1'b0, 0, 4, 1'b0, 1'b1, 3'b100});
    tbl.push_back('{"lw",    32'h0080A283, 1'b0, 2, 7, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"lw0",   32'h0080A283, 1'b0, 0, 5, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"sw",    32'h0020A223, 1'b0, 1, 5, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"sw0",   32'h0020A223, 1'b0, 0, 4, 1'b0, 1'b1, 3'b000});
    tbl.push_back('{"slt",   32'h0020A1B3, 1'b0, 0, 3, 1'b1, 1'b0, 3'b000});
    tbl.push_back('{"lb",    32'h00008283, 1'b0, 0, 3, 1'b1, 1'b1, 3'b000});
    tbl.push_back('{"badop", 32'h0000007F, 1'b0, 0, 2, 1'b1, 1'b1, 3'b000});
    if (BR_EN) begin
      tbl.push_back('{"beq_t", 32'h00208463, 1'b1, 0, 3, 1'b0, 1'b1, 3'b001});
      tbl.push_back('{"beq_n", 32'h00208463, 1'b0, 0, 3, 1'b0, 1'b1, 3'b001});
      tbl.push_back('{"bne",   32'h00209463, 1'b0, 0, 3, 1'b0, 1'b1, 3'b001});
      tbl.push_back('{"jal",   32'h008000EF, 1'b0, 0, 4, 1'b0, 1'b1, 3'b000});
      tbl.push_back('{"blt",   32'h0020C463, 1'b1, 0, 3, 1'b1, 1'b1, 3'b001});
    end else begin
      tbl.push_back('{"beq",   32'h00208463, 1'b1, 0, 2, 1'b1, 1'b1, 3'b000});
      tbl.push_back('{"jal",   32'h008000EF, 1'b0, 0, 2, 1'b1, 1'b1, 3'b000});
    end

    foreach (tbl[t]) begin
      run_instr(tbl[t].name, tbl[t].i, 1'b0, tbl[t].z, tbl[t].waits, cyc, ill, op2);
      checks++;
      if (cyc != tbl[t].cyc) begin
        failures++;
        $display("FAIL %s latency got=%0d required=%0d", tbl[t].name, cyc, tbl[t].cyc);
      end
      checks++;
      if (ill !== tbl[t].ill) begin
        failures++;
        $display("FAIL %s illegal_path got=%0b required=%0b", tbl[t].name, ill, tbl[t].ill);
      end
      if (tbl[t].chk_op) begin
        checks++;
        if (op2 !== tbl[t].op) begin
          failures++;
          $display("FAIL %s alu_op_cycle3 got=%b required=%b", tbl[t].name, op2, tbl[t].op);
        end
      end
      if (ill) do_reset(1);
    end

    // Reset while a store is stalled: request must drop at once, then refetch
    instr = 32'h0020A223;
    step(K_FETCH, 1'b1, 1'b0, "sw_abort", dummy);
    step(K_DEC,   1'b0, 1'b0, "sw_abort", dummy);
    step(K_MADR,  1'b0, 1'b0, "sw_abort", dummy);
    step(K_MWR,   1'b0, 1'b0, "sw_abort", dummy);
    step(K_MWR,   1'b0, 1'b0, "sw_abort", dummy);
    do_reset(1);
    step(K_FETCH, 1'b0, 1'b0, "sw_abort_refetch", dummy);

    // Randomized instruction stream with random memory wait states
    for (int n = 0; n < 250; n++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0:       opc = 7'b0110011;
        1:       opc = 7'b0010011;
        2:       opc = 7'b0000011;
        3:       opc = 7'b0100011;
        4:       opc = 7'b1100011;
        5:       opc = 7'b1101111;
        default: opc = 7'($urandom);
      endcase
      r[6:0] = opc;
      if ((opc == 7'b0000011 || opc == 7'b0100011) && $urandom_range(0, 3) != 0) r[14:12] = 3'b010;
      if (opc == 7'b1100011 && $urandom_range(0, 3) != 0) r[14:13] = 2'b00;
      run_instr("random", r, 1'b1, 1'b0, 0, cyc, ill, op2);
      if (ill) do_reset(1 + int'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
